// File: rtl/i2c_master_burst_pkg.sv
// i2c_pkg: shared constants for the burst I2C master.
// FSM state encodings, quarter-phase names, ACK/NACK bus levels and the
// quarter-length helper.
package i2c_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_WR_BYTE  = 4'd4;
  localparam logic [3:0] S_WR_ACK   = 4'd5;
  localparam logic [3:0] S_RD_BYTE  = 4'd6;
  localparam logic [3:0] S_RD_ACK   = 4'd7;
  localparam logic [3:0] S_STOP     = 4'd8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // System clocks per quarter bit period.
  function automatic int quarter_clks(input int sys_f, input int i2c_f);
    return sys_f / i2c_f / 4;
  endfunction

endpackage

// File: rtl/i2c_master_burst_if.sv
// Front-end handshake bundle for i2c_master_burst.
// master = register/DMA side, slave = the I2C engine.
interface i2c_master_burst_if #(parameter int LEN_W = 4);
  logic             start;
  logic [6:0]       addr;
  logic             op;
  logic [LEN_W-1:0] len;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             done;
  logic             ack_err;

  modport master (output start, addr, op, len, tx_data, tx_valid,
                  input  tx_ready, rx_data, rx_valid, busy, done, ack_err);
  modport slave  (input  start, addr, op, len, tx_data, tx_valid,
                  output tx_ready, rx_data, rx_valid, busy, done, ack_err);
endinterface

// File: rtl/i2c_master_burst_qtick_gen.sv
// i2c_qtick_gen: quarter-bit phase counter. Each quarter lasts Q clocks;
// hold freezes the count (tx stall or clock stretch), run=0 rewinds to q0.
module i2c_qtick_gen
  import i2c_pkg::*;
#(
  parameter int SYS_FREQ = 4000000,
  parameter int I2C_FREQ = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  output logic [1:0] phase,
  output logic       q_end,
  output logic       last_clk
);
  localparam int Q  = quarter_clks(SYS_FREQ, I2C_FREQ);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;

  logic [CW-1:0] cnt_q;
  logic [1:0]    phase_q;

  assign q_end    = run && !hold && (cnt_q == CW'(Q - 1));
  assign last_clk = q_end && (phase_q == Q3);
  assign phase    = phase_q;

  // Advance clock count, roll into the next quarter at its final clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else if (!run) begin
      cnt_q   <= '0;
      phase_q <= Q0;
    end else if (!hold) begin
      if (q_end) begin
        cnt_q   <= '0;
        phase_q <= phase_q + 2'd1;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_master_burst.sv
// i2c_master_burst: N-byte burst I2C master (write or read, one 7-bit slave).
// Optional macro I2C_CLK_STRETCH_EN: hold SCL-high timing while the pad
// sense scl_in is still low (slave clock stretching). Without it scl_in is
// ignored.
module i2c_master_burst
  import i2c_pkg::*;
#(
  parameter int SYS_FREQ = 4000000,
  parameter int I2C_FREQ = 100000,
  parameter int LEN_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  i2c_master_burst_if.slave   bus,
  inout  wire                 sda,
  output logic                scl,
  input  logic                scl_in
);
  logic [3:0]       state_q, state_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rxsh_q, rxsh_d;
  logic [7:0]       rxd_q, rxd_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             have_q, have_d;
  logic             samp_q, samp_d;
  logic             err_q, err_d;
  logic             rxv_q, rxv_d;

  logic [1:0] phase;
  logic       q_end, last_clk, stall, stretch, sda_oe, sda_in;

  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  // Byte source not ready at the start of a write byte: freeze the bit clock.
  assign stall = (state_q == S_WR_BYTE) && !have_q && !bus.tx_valid;

`ifdef I2C_CLK_STRETCH_EN
  assign stretch = (state_q != S_IDLE) && (phase == Q2) && !scl_in;
`else
  logic unused_scl_in;
  assign stretch       = 1'b0;
  assign unused_scl_in = scl_in;
`endif

  i2c_qtick_gen #(.SYS_FREQ(SYS_FREQ), .I2C_FREQ(I2C_FREQ)) u_qtick (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q != S_IDLE),
    .hold     (stall || stretch),
    .phase    (phase),
    .q_end    (q_end),
    .last_clk (last_clk)
  );

  assign bus.tx_ready = (state_q == S_WR_BYTE) && !have_q && bus.tx_valid;
  assign bus.done     = (state_q == S_STOP) && last_clk;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.ack_err  = err_q;
  assign bus.rx_data  = rxd_q;
  assign bus.rx_valid = rxv_q;

  // Pad drive per state; SCL low in q0-q1, high in q2-q3 inside a transfer.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state_q)
      S_START:   sda_oe = phase[1];
      S_ADDR:    begin scl = phase[1]; sda_oe = !sh_q[7]; end
      S_WR_BYTE: begin
        scl    = phase[1];
        sda_oe = have_q ? !sh_q[7] : !bus.tx_data[7];
      end
      S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: scl = phase[1];
      S_RD_ACK:  begin scl = phase[1]; sda_oe = (cnt_q > LEN_W'(1)); end
      S_STOP:    begin scl = phase[1]; sda_oe = (phase != Q3); end
      default:   ;
    endcase
  end

  // Transfer sequencing, byte latching and bus sampling.
  always_comb begin
    state_d = state_q; bit_d = bit_q; sh_d = sh_q; rxsh_d = rxsh_q;
    rxd_d = rxd_q; cnt_d = cnt_q; op_d = op_q; have_d = have_q;
    samp_d = samp_q; err_d = err_q; rxv_d = 1'b0;
    if (bus.tx_ready) begin
      sh_d   = bus.tx_data;
      have_d = 1'b1;
    end
    if (q_end && phase == Q2) begin
      samp_d = sda_in;
      if (state_q == S_RD_BYTE) rxsh_d = {rxsh_q[6:0], sda_in};
    end
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_START;
        sh_d    = {bus.addr, bus.op};
        op_d    = bus.op;
        cnt_d   = bus.len;
        err_d   = 1'b0;
        bit_d   = 3'd7;
      end
    end else if (last_clk) begin
      case (state_q)
        S_START: state_d = S_ADDR;
        S_ADDR, S_WR_BYTE: begin
          if (bit_q == 3'd0) state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
          else begin
            bit_d = bit_q - 3'd1;
            sh_d  = {sh_q[6:0], 1'b0};
          end
        end
        S_RD_BYTE: begin
          if (bit_q == 3'd0) state_d = S_RD_ACK;
          else bit_d = bit_q - 3'd1;
        end
        S_ADDR_ACK: begin
          bit_d  = 3'd7;
          have_d = 1'b0;
          if (samp_q == NACK) begin
            err_d   = 1'b1;
            state_d = S_STOP;
          end else if (cnt_q == '0) state_d = S_STOP;
          else state_d = op_q ? S_RD_BYTE : S_WR_BYTE;
        end
        S_WR_ACK: begin
          cnt_d  = (cnt_q != '0) ? cnt_q - LEN_W'(1) : '0;
          bit_d  = 3'd7;
          have_d = 1'b0;
          if (samp_q == NACK) begin
            err_d   = 1'b1;
            state_d = S_STOP;
          end else state_d = (cnt_q > LEN_W'(1)) ? S_WR_BYTE : S_STOP;
        end
        S_RD_ACK: begin
          cnt_d   = (cnt_q != '0) ? cnt_q - LEN_W'(1) : '0;
          bit_d   = 3'd7;
          rxd_d   = rxsh_q;
          rxv_d   = 1'b1;
          state_d = (cnt_q > LEN_W'(1)) ? S_RD_BYTE : S_STOP;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset abandons any transfer with the bus released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE; bit_q <= '0; sh_q <= '0; rxsh_q <= '0; rxd_q <= '0;
      cnt_q <= '0; op_q <= 1'b0; have_q <= 1'b0; samp_q <= 1'b0;
      err_q <= 1'b0; rxv_q <= 1'b0;
    end else begin
      state_q <= state_d; bit_q <= bit_d; sh_q <= sh_d; rxsh_q <= rxsh_d;
      rxd_q <= rxd_d; cnt_q <= cnt_d; op_q <= op_d; have_q <= have_d;
      samp_q <= samp_d; err_q <= err_d; rxv_q <= rxv_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: behavioural open-drain slave on the pads,
// table of burst transfers plus hand-written stall / reset sequences.
module tb_i2c_master_burst;
  localparam int LEN_W = 4;

  typedef struct {
    logic            op;
    logic [3:0]      len;
    logic [2:0][7:0] wd;       // bytes offered on tx stream
    logic [1:0][7:0] rd;       // bytes the slave returns
    int              nack_fr;  // frame index the slave NACKs (-1 none)
    bit              slv_en;   // slave present
    logic            err;
    int              nfr;      // master-written frames seen on the bus
    logic [3:0][7:0] fr;
    int              ntx;
    int              nrx;
    logic [1:0][7:0] rx;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl, scl_in, slv_pull;
  wire  sda;

  pullup (sda);
  assign sda = slv_pull ? 1'b0 : 1'bz;

  i2c_master_burst_if #(.LEN_W(LEN_W)) bus ();

  i2c_master_burst #(.SYS_FREQ(4000000), .I2C_FREQ(100000), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sda(sda), .scl(scl), .scl_in(scl_in)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // monitor-owned
  int         txr_n = 0;
  int         done_n = 0;
  logic [7:0] cap[$];
  logic [7:0] rxq[$];
  bit         macks[$];
  // main-owned
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  bit         slv_en = 1'b1;
  int         nack_fr = -1;
  int         b_cap, b_tx, b_rx, b_mk, b_done;

  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // tx stream: present the head of wq, pop it when the DUT consumes it
  initial begin
    bus.tx_data = 8'h00;
    forever begin
      bit took;
      @(negedge clk);
      took = bus.tx_ready && (wq.size() > 0);
      @(posedge clk);
      #1;
      if (took) void'(wq.pop_front());
      bus.tx_data = (wq.size() > 0) ? wq[0] : 8'h00;
    end
  end

  // front-end monitor and behavioural I2C slave
  initial begin
    logic s, d, p_scl, p_sda, act, rdm, nacked;
    logic [7:0] sh, rb;
    int bitc, frame;
    slv_pull = 1'b0; p_scl = 1'b1; p_sda = 1'b1; act = 1'b0; rdm = 1'b0;
    nacked = 1'b0; sh = '0; bitc = 0; frame = 0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready) txr_n++;
      if (bus.done) done_n++;
      if (bus.rx_valid) rxq.push_back(bus.rx_data);
      s = scl; d = sda;
      if (s && p_scl && p_sda && !d) begin
        act = 1'b1; bitc = -1; frame = 0; nacked = 1'b0; slv_pull = 1'b0;
      end else if (s && p_scl && !p_sda && d) begin
        act = 1'b0; slv_pull = 1'b0;
      end else if (act && s && !p_scl) begin
        if (bitc >= 0 && bitc < 8) sh = {sh[6:0], d};
        if (bitc == 8 && frame > 0 && rdm) begin
          macks.push_back(d);
          if (d) nacked = 1'b1;
        end
      end else if (act && !s && p_scl) begin
        bitc++;
        slv_pull = 1'b0;
        if (bitc == 8) begin
          if (!(frame > 0 && rdm)) begin
            cap.push_back(sh);
            if (frame == 0) rdm = sh[0];
            slv_pull = slv_en && (frame != nack_fr);
          end
        end else begin
          if (bitc == 9) begin
            bitc = 0;
            frame++;
          end
          if (frame > 0 && rdm && !nacked && slv_en && bitc < 8) begin
            rb = (frame - 1 < rq.size()) ? rq[frame-1] : 8'hFF;
            slv_pull = !rb[7-bitc];
          end
        end
      end
      p_scl = s; p_sda = d;
    end
  end

  task automatic setup(input vec_t v);
    wq.delete();
    for (int j = 0; j < 3; j++) if (j < int'(v.len)) wq.push_back(v.wd[j]);
    rq.delete();
    rq.push_back(v.rd[0]);
    rq.push_back(v.rd[1]);
    slv_en  = v.slv_en;
    nack_fr = v.nack_fr;
    b_cap = cap.size(); b_tx = txr_n; b_rx = rxq.size(); b_mk = macks.size(); b_done = done_n;
  endtask

  // one transfer, with a stray start mid-flight that must be ignored
  task automatic run_xfer(input logic op, input logic [3:0] len);
    int n;
    @(posedge clk); #1;
    bus.addr = 7'h50; bus.op = op; bus.len = len; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.addr = 7'h11; bus.len = 4'd1;
    repeat (100) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0;
    while (done_n == b_done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done_n != b_done), 1);
    repeat (100) @(negedge clk);
    chk("busy_after", 32'(bus.busy), 0);
    chk("done_once", 32'(done_n - b_done), 1);
  endtask

  task automatic check_vec(input string nm, input vec_t v);
    chk({nm, ".ack_err"}, 32'(bus.ack_err), 32'(v.err));
    chk({nm, ".nframes"}, 32'(cap.size() - b_cap), 32'(v.nfr));
    for (int j = 0; j < v.nfr; j++)
      chk($sformatf("%s.frame%0d", nm, j),
          (b_cap + j < cap.size()) ? 32'(cap[b_cap+j]) : 32'hDEAD, 32'(v.fr[j]));
    chk({nm, ".tx_ready"}, 32'(txr_n - b_tx), 32'(v.ntx));
    chk({nm, ".rx_valid"}, 32'(rxq.size() - b_rx), 32'(v.nrx));
    for (int j = 0; j < v.nrx; j++) begin
      chk($sformatf("%s.rx%0d", nm, j),
          (b_rx + j < rxq.size()) ? 32'(rxq[b_rx+j]) : 32'hDEAD, 32'(v.rx[j]));
      chk($sformatf("%s.mack%0d", nm, j),
          (b_mk + j < macks.size()) ? 32'(macks[b_mk+j]) : 32'hDEAD, 32'(j == v.nrx - 1));
    end
    chk({nm, ".scl_idle"}, 32'(scl), 1);
    chk({nm, ".sda_idle"}, 32'(sda), 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lowc;
    vec_t vr;
    bit ok;

    vt[0] = '{op:1'b0, len:4'd3, wd:{8'hFF, 8'h3C, 8'hA5}, rd:'0, nack_fr:-1, slv_en:1'b1,
              err:1'b0, nfr:4, fr:{8'hFF, 8'h3C, 8'hA5, 8'hA0}, ntx:3, nrx:0, rx:'0};
    vt[1] = '{op:1'b1, len:4'd2, wd:'0, rd:{8'h7E, 8'h81}, nack_fr:-1, slv_en:1'b1,
              err:1'b0, nfr:1, fr:{24'h0, 8'hA1}, ntx:0, nrx:2, rx:{8'h7E, 8'h81}};
    vt[2] = '{op:1'b0, len:4'd3, wd:{8'hFF, 8'h3C, 8'hA5}, rd:'0, nack_fr:2, slv_en:1'b1,
              err:1'b1, nfr:3, fr:{8'h00, 8'h3C, 8'hA5, 8'hA0}, ntx:2, nrx:0, rx:'0};
    vt[3] = '{op:1'b0, len:4'd0, wd:'0, rd:'0, nack_fr:-1, slv_en:1'b0,
              err:1'b1, nfr:1, fr:{24'h0, 8'hA0}, ntx:0, nrx:0, rx:'0};

    bus.start = 1'b0; bus.addr = '0; bus.op = 1'b0; bus.len = '0; bus.tx_valid = 1'b0;
    scl_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.scl", 32'(scl), 1);
    chk("rst.sda", 32'(sda), 1);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.ack_err", 32'(bus.ack_err), 0);
    chk("rst.tx_ready", 32'(bus.tx_ready), 0);
    chk("rst.rx_valid", 32'(bus.rx_valid), 0);
    chk("rst.rx_data", 32'(bus.rx_data), 0);
    @(posedge clk); #1 rst = 1'b1;
    bus.tx_valid = 1'b1;

    for (int i = 0; i < 4; i++) begin
      setup(vt[i]);
      run_xfer(vt[i].op, vt[i].len);
      check_vec($sformatf("vec%0d", i), vt[i]);
    end

    // tx source stalls at the second write byte
    setup(vt[0]);
    fork
      run_xfer(1'b0, 4'd3);
      begin
        n = 0;
        while (txr_n == b_tx && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk); #1 bus.tx_valid = 1'b0;
        lowc = 0; n = 0;
        while (lowc < 25 && n < 3000) begin
          @(negedge clk); n++;
          if (!scl) lowc++; else lowc = 0;
        end
        chk("stall.reached", 32'(lowc >= 25), 1);
        ok = 1'b1;
        repeat (40) begin
          @(negedge clk);
          if (scl) ok = 1'b0;
          lowc++;
        end
        @(posedge clk); #1 bus.tx_valid = 1'b1;
        n = 0;
        while (!scl && n < 200) begin
          @(negedge clk); n++;
          if (!scl) lowc++;
        end
        chk("stall.scl_held", 32'(ok), 1);
        chk("stall.low_len", 32'(lowc >= 60), 1);
      end
    join
    check_vec("stall", vt[0]);

    // reset in the middle of a read byte
    vr = vt[1];
    vr.rd = {8'hFF, 8'hFF};
    setup(vr);
    @(posedge clk); #1;
    bus.addr = 7'h50; bus.op = 1'b1; bus.len = 4'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (500) @(negedge clk);
    chk("rstmid.busy_before", 32'(bus.busy), 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("rstmid.scl", 32'(scl), 1);
    chk("rstmid.sda", 32'(sda), 1);
    chk("rstmid.busy", 32'(bus.busy), 0);
    @(posedge clk); #1 rst = 1'b1;

    // bus recovers on the next START: probe a present slave
    vr = vt[3];
    vr.slv_en = 1'b1;
    vr.err = 1'b0;
    setup(vr);
    run_xfer(1'b0, 4'd0);
    check_vec("recover", vr);

`ifdef I2C_CLK_STRETCH_EN
    setup(vr);
    fork
      run_xfer(1'b0, 4'd0);
      begin
        int hc;
        n = 0;
        while (!bus.busy && n < 100) begin @(negedge clk); n++; end
        while (scl && n < 400) begin @(negedge clk); n++; end
        while (!scl && n < 400) begin @(negedge clk); n++; end
        hc = 1;
        scl_in = 1'b0;
        repeat (100) begin
          @(negedge clk);
          if (scl) hc++;
        end
        scl_in = 1'b1;
        n = 0;
        while (scl && n < 200) begin
          @(negedge clk); n++;
          if (scl) hc++;
        end
        chk("stretch.high_len", 32'(hc), 120);
      end
    join
    check_vec("stretch", vr);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
